// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider / tick generator.
// Each channel has a runtime-loadable divisor and a square-wave or single-pulse output mode.
module clk_div_multi #(
    parameter int unsigned NUM_CH       = 4,
    parameter int unsigned CH_W         = 2,
    parameter int unsigned WIDTH        = 11,
    parameter int unsigned DEFAULT_DIV  = 2047,
    parameter bit          DEFAULT_MODE = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] en,
    input  logic              sync_clr,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [CH_W-1:0]   ld_ch,
    input  logic [WIDTH-1:0]  ld_div,
    input  logic              ld_mode,
    output logic              ld_err,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] clk_out
);

    localparam logic [WIDTH-1:0] DefDiv = WIDTH'(DEFAULT_DIV);

    logic [WIDTH-1:0]  cnt_q [NUM_CH];
    logic [WIDTH-1:0]  cnt_d [NUM_CH];
    logic [WIDTH-1:0]  div_q [NUM_CH];
    logic [WIDTH-1:0]  div_d [NUM_CH];
    logic [NUM_CH-1:0] mode_q, mode_d;
    logic [NUM_CH-1:0] tick_q, tick_d;
    logic [NUM_CH-1:0] clk_out_q, clk_out_d;
    logic              ld_ready_q;
    logic              ld_err_q, ld_err_d;

    // Widened so the range check stays meaningful when 2^CH_W == NUM_CH.
    logic [31:0] ld_ch_ext;
    logic        ld_fire;

    always_comb begin
        ld_ch_ext = 32'(ld_ch);
        ld_fire   = ld_valid & ld_ready_q;
        ld_err_d  = ld_fire & (ld_ch_ext >= NUM_CH);

        for (int unsigned i = 0; i < NUM_CH; i++) begin
            cnt_d[i]     = cnt_q[i];
            div_d[i]     = div_q[i];
            mode_d[i]    = mode_q[i];
            tick_d[i]    = 1'b0;
            // Square wave holds between terminal counts; pulse mode mirrors tick.
            clk_out_d[i] = mode_q[i] ? 1'b0 : clk_out_q[i];

            if (sync_clr) begin
                cnt_d[i]     = '0;
                clk_out_d[i] = 1'b0;
            end else if (ld_fire && (ld_ch_ext == i)) begin
                div_d[i]     = ld_div;
                mode_d[i]    = ld_mode;
                cnt_d[i]     = '0;
                clk_out_d[i] = 1'b0;
            end else if (div_q[i] == '0) begin
                cnt_d[i]     = '0;
                clk_out_d[i] = 1'b0;
            end else if (en[i]) begin
                if (cnt_q[i] == div_q[i]) begin
                    cnt_d[i]     = '0;
                    tick_d[i]    = 1'b1;
                    clk_out_d[i] = mode_q[i] ? 1'b1 : ~clk_out_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= '0;
                div_q[i] <= DefDiv;
            end
            mode_q     <= {NUM_CH{DEFAULT_MODE}};
            tick_q     <= '0;
            clk_out_q  <= '0;
            ld_ready_q <= 1'b0;
            ld_err_q   <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= cnt_d[i];
                div_q[i] <= div_d[i];
            end
            mode_q     <= mode_d;
            tick_q     <= tick_d;
            clk_out_q  <= clk_out_d;
            ld_ready_q <= 1'b1;
            ld_err_q   <= ld_err_d;
        end
    end

    assign ld_ready = ld_ready_q;
    assign ld_err   = ld_err_q;
    assign tick     = tick_q;
    assign clk_out  = clk_out_q;

endmodule

// File: tb/tb_clk_div_multi.sv
// Randomised and directed bench for clk_div_multi against an arithmetic reference model.
module tb_clk_div_multi;

    localparam int NCH  = 4;
    localparam int CHW  = 3;
    localparam int W    = 11;
    localparam int DDIV = 2047;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [NCH-1:0] en = '1;
    logic           sync_clr = 1'b0;
    logic           ld_valid = 1'b0;
    logic [CHW-1:0] ld_ch = '0;
    logic [W-1:0]   ld_div = '0;
    logic           ld_mode = 1'b0;
    logic           ld_ready;
    logic           ld_err;
    logic [NCH-1:0] tick;
    logic [NCH-1:0] clk_out;

    clk_div_multi #(
        .NUM_CH      (NCH),
        .CH_W        (CHW),
        .WIDTH       (W),
        .DEFAULT_DIV (DDIV),
        .DEFAULT_MODE(1'b0)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .sync_clr(sync_clr),
        .ld_valid(ld_valid),
        .ld_ready(ld_ready),
        .ld_ch   (ld_ch),
        .ld_div  (ld_div),
        .ld_mode (ld_mode),
        .ld_err  (ld_err),
        .tick    (tick),
        .clk_out (clk_out)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Model: a channel's outputs follow from how many counting cycles it has
    // seen since its last restart (load, sync_clr, reset).
    int             steps[NCH];
    int             mdiv[NCH];
    bit             mmode[NCH];
    bit             m_ready;
    bit             m_err;
    logic [NCH-1:0] m_tick;
    logic [NCH-1:0] m_clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic model_edge();
        bit fire;
        bit counted;
        if (!rst) begin
            for (int c = 0; c < NCH; c++) begin
                steps[c] = 0;
                mdiv[c]  = DDIV;
                mmode[c] = 1'b0;
            end
            m_ready = 1'b0;
            m_err   = 1'b0;
            m_tick  = '0;
            m_clk   = '0;
        end else begin
            fire  = m_ready && ld_valid;
            m_err = fire && (int'(ld_ch) >= NCH);
            for (int c = 0; c < NCH; c++) begin
                counted = 1'b0;
                if (sync_clr) begin
                    steps[c] = 0;
                end else if (fire && int'(ld_ch) == c) begin
                    mdiv[c]  = int'(ld_div);
                    mmode[c] = ld_mode;
                    steps[c] = 0;
                end else if (mdiv[c] == 0) begin
                    steps[c] = 0;
                end else if (en[c]) begin
                    steps[c]++;
                    counted = 1'b1;
                end
                m_tick[c] = counted && mdiv[c] != 0 && (steps[c] % (mdiv[c] + 1) == 0);
                if (mmode[c]) m_clk[c] = m_tick[c];
                else if (mdiv[c] == 0) m_clk[c] = 1'b0;
                else m_clk[c] = ((steps[c] / (mdiv[c] + 1)) % 2) == 1;
            end
            m_ready = 1'b1;
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        check_eq("tick", 32'(tick), 32'(m_tick));
        check_eq("clk_out", 32'(clk_out), 32'(m_clk));
        check_eq("ld_ready", 32'(ld_ready), 32'(m_ready));
        check_eq("ld_err", 32'(ld_err), 32'(m_err));
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cyc();
    endtask

    task automatic load(input int ch, input int d, input bit m);
        ld_valid = 1'b1;
        ld_ch    = CHW'(ch);
        ld_div   = W'(d);
        ld_mode  = m;
        cyc();
        ld_valid = 1'b0;
    endtask

    initial begin
        int found;

        // Reset, then defaults: period 2048 ticks, 4096 square wave.
        run(3);
        rst = 1'b1;
        cyc();
        check_eq("ld_ready_rise", 32'(ld_ready), 32'd1);
        run(4200);

        // Custom divisors on ch1 (square) and ch2 (pulse).
        load(1, 4, 1'b0);
        load(2, 2, 1'b1);
        run(40);

        // Enable gap on ch1 mid-count.
        run(2);
        en[1] = 1'b0;
        run(7);
        en[1] = 1'b1;
        run(20);

        // Stopped channel and out-of-range load.
        load(3, 0, 1'b0);
        run(10);
        check_eq("ch3_stopped", 32'({tick[3], clk_out[3]}), 32'd0);
        load(5, 9, 1'b1);
        check_eq("ld_err_pulse", 32'(ld_err), 32'd1);
        cyc();
        check_eq("ld_err_drop", 32'(ld_err), 32'd0);
        run(10);

        // Load ch1 on the cycle it would hit terminal count.
        found = 0;
        for (int k = 0; k < 20 && found == 0; k++) begin
            if (steps[1] % 5 == 4) found = 1;
            else cyc();
        end
        check_eq("tc_wait", 32'(found), 32'd1);
        load(1, 4, 1'b0);
        check_eq("tc_load_no_tick", 32'(tick[1]), 32'd0);
        run(12);

        // Phase alignment: ch1 (D=4) and ch2 (D=2) coincide 15 cycles later.
        sync_clr = 1'b1;
        cyc();
        sync_clr = 1'b0;
        run(15);
        check_eq("sync_phase", 32'(tick[2:1]), 32'd3);
        run(5);

        // Mid-run reset returns divisors to defaults.
        rst = 1'b0;
        cyc();
        check_eq("rst_ready_low", 32'(ld_ready), 32'd0);
        rst = 1'b1;
        cyc();
        check_eq("rst_ready_high", 32'(ld_ready), 32'd1);
        run(2100);

        // Random traffic.
        for (int k = 0; k < 4000; k++) begin
            for (int c = 0; c < NCH; c++) en[c] = ($urandom_range(0, 7) != 0);
            sync_clr = ($urandom_range(0, 63) == 0);
            rst      = ($urandom_range(0, 499) != 0);
            ld_valid = ($urandom_range(0, 7) == 0);
            ld_ch    = CHW'($urandom_range(0, 7));
            ld_mode  = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 9))
                0:       ld_div = W'(2047);
                1:       ld_div = W'($urandom_range(0, 2047));
                default: ld_div = W'($urandom_range(0, 9));
            endcase
            cyc();
        end
        rst      = 1'b1;
        ld_valid = 1'b0;
        sync_clr = 1'b0;
        run(5);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/clk_div_multi.md
Name: clk_div_multi

Overview:
- Multi-channel programmable clock divider and tick generator; next-generation replacement for the fixed single-channel divider.
- NUM_CH independent channels, each with a runtime-loadable divisor and a mode: 50% square wave or single-cycle pulse.
- Sits next to the board clock. Feeds display multiplexing, debounce sampling and slow FSM enables.
- Also provides a global phase-align clear.

Parameters:
- NUM_CH, 4: number of divider channels (1..16).
- CH_W, 2: width of the channel select; must satisfy 2^CH_W >= NUM_CH.
- WIDTH, 11: counter and divisor width per channel.
- DEFAULT_DIV, 2047: divisor loaded into every channel at reset.
- DEFAULT_MODE, 0: mode loaded into every channel at reset (0 = square, 1 = pulse).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-low.
- en  in  NUM_CH  per-channel count enable.
- sync_clr  in  1  clears all channel counters and outputs in the same cycle (phase alignment).
- ld_valid  in  1  divisor load request.
- ld_ready  out  1  load accepted when ld_valid and ld_ready are both high at a posedge.
- ld_ch  in  CH_W  target channel of the load.
- ld_div  in  WIDTH  new divisor D.
- ld_mode  in  1  new mode M.
- ld_err  out  1  one-cycle pulse: load addressed to ld_ch >= NUM_CH.
- tick  out  NUM_CH  one-cycle enable pulse per channel at terminal count.
- clk_out  out  NUM_CH  divided output: square wave (M=0) or copy of tick (M=1).

Behaviour:
- Clocking and priority:
  - All state is updated on posedge clk; all outputs are registered.
  - Priority per channel: rst > sync_clr > accepted load to this channel > counting.
- Reset (rst=0 at posedge):
  - cnt[i]=0, D[i]=DEFAULT_DIV, M[i]=DEFAULT_MODE.
  - tick=0, clk_out=0, ld_ready=0, ld_err=0.
- ld_ready:
  - Goes 1 at the first posedge with rst=1 and stays 1.
  - Loads are never back-pressured after that.
- Counting (channel i, en[i]=1, D[i]!=0):
  - If cnt[i]!=D[i]: cnt[i]<=cnt[i]+1 and tick[i]<=0.
  - If cnt[i]==D[i]: cnt[i]<=0 and tick[i]<=1.
  - Tick period is D+1 cycles; tick high for exactly 1 cycle.
- Mode 0:
  - clk_out[i] toggles at every terminal count.
  - Period 2(D+1) cycles, 50% duty.
  - First rising edge appears D+1 cycles after counting starts from cnt=0.
- Mode 1:
  - clk_out[i] is driven with the same value as tick[i], in the same cycle.
- en[i]=0:
  - cnt[i] and the mode-0 clk_out[i] hold their values.
  - tick[i]=0; in mode 1, clk_out[i]=0.
  - Counting resumes from the held cnt with no lost or extra ticks.
- D[i]=0:
  - Channel stopped: cnt[i] held at 0, tick[i]=0, clk_out[i]=0.
  - A divide-by-1 is not supported.
- Accepted load (ld_valid=1, ld_ready=1, ld_ch<NUM_CH):
  - At that edge: D[ld_ch]<=ld_div, M[ld_ch]<=ld_mode, cnt<=0, clk_out<=0, tick<=0.
  - New timing starts on the next cycle.
  - Other channels are unaffected.
- Invalid load (ld_ch >= NUM_CH):
  - No state change.
  - ld_err=1 for exactly the next cycle; otherwise ld_err=0.
- Load on a terminal-count cycle of the same channel:
  - The load wins; no tick and no toggle occur.
- sync_clr=1:
  - All cnt, tick and clk_out are cleared.
  - D and M are retained.
  - Any load presented in the same cycle is dropped; ld_err is still reported for an out-of-range ld_ch.
- rst asserted mid-operation:
  - All state returns to reset values at that edge, including loaded divisors (back to DEFAULT_DIV).
- Arithmetic:
  - The counter never exceeds D.
  - D = 2^WIDTH-1 is valid, giving a maximum tick period of 2^WIDTH cycles with no wrap glitch.

Test Plan:
1. Reset release, defaults (WIDTH=11, DEFAULT_DIV=2047), en=all 1 -> every channel ticks every 2048 cycles; clk_out toggles every 2048 cycles (period 4096); ld_ready rises 1 cycle after reset release.
2. Load ch1 D=4 M=0, then ch2 D=2 M=1 -> ch1 tick every 5 cycles, clk_out[1] period 10, 50% duty; ch2 tick = clk_out[2], 1-cycle pulse every 3 cycles; ch0/ch3 phase undisturbed.
3. Drop en[1] for 7 cycles mid-count on ch1 (D=4) -> no ticks and clk_out[1] frozen during the gap; the next tick occurs exactly 5 - (cycles already counted) enabled cycles after en returns.
4. Load ch3 D=0 -> tick[3]=0 and clk_out[3]=0 indefinitely. Load ld_ch=5 with NUM_CH=4, CH_W=3 -> ld_err high 1 cycle, all channels unchanged.
5. Load ch1 on its terminal-count cycle -> no tick that cycle, cnt restarts at 0. Assert sync_clr -> all channels restart in phase; ch1 (D=4) and ch2 (D=2) both tick together again 15 cycles later.
6. Assert rst=0 for 1 cycle mid-run after custom loads -> all divisors return to 2047, outputs 0, ld_ready 0 for that cycle then 1.
